// File: rtl/md_host_sequencer.sv
// -----------------------------------------------------------------------------
// md_host_sequencer
//
// Host-side controller for one MD_Wrapper run. For each timestep it:
//   1. loads N particle records from a 1-cycle-latency source BRAM into the
//      MD core, one md_elem_write strobe per (2 + WR_GAP) cycles,
//   2. waits COMPUTE_CYCLES cycles with every strobe low,
//   3. drains N results through the md_read_ctrl / md_elem_read handshake
//      into a result buffer (res_* appear the cycle after md_elem_read),
//   4. advances md_step.
// The load/compute/drain cycle repeats for num_steps timesteps, then done
// pulses for one cycle. A missing md_elem_read for RD_TIMEOUT cycles sets
// the sticky error flag and aborts the run without done.
//
// Ports
//   ap_clk, ap_rst_n        clock, asynchronous active-low reset
//   start                   one-cycle start pulse, honoured only when idle
//   num_particles           particle count N, sampled on accepted start
//   num_steps               timestep count, sampled on accepted start
//   src_en, src_addr        source BRAM read port
//   src_data                source BRAM data, valid the cycle after src_en
//   md_d_in, md_elem_write  record and write strobe to the MD core
//   md_step                 current timestep index to the MD core
//   md_read_ctrl            one-cycle result request to the MD core
//   md_elem_read, md_d_out  result strobe and data from the MD core
//   res_wr_en, res_addr,
//   res_data                result buffer write port
//   busy                    high whenever the sequencer is not idle
//   done                    one-cycle pulse on normal completion
//   error                   sticky read-timeout flag, cleared by next start
// -----------------------------------------------------------------------------
module md_host_sequencer #(
   parameter int ADDR_W         = 9,
   parameter int DIN_W          = 210,
   parameter int DOUT_W         = 192,
   parameter int WR_GAP         = 2,
   parameter int COMPUTE_CYCLES = 10000,
   parameter int RD_TIMEOUT     = 1023
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_particles,
   input  logic [31:0]       num_steps,
   output logic              src_en,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [DIN_W-1:0]  src_data,
   output logic [DIN_W-1:0]  md_d_in,
   output logic              md_elem_write,
   output logic [31:0]       md_step,
   output logic              md_read_ctrl,
   input  logic              md_elem_read,
   input  logic [DOUT_W-1:0] md_d_out,
   output logic              res_wr_en,
   output logic [ADDR_W-1:0] res_addr,
   output logic [DOUT_W-1:0] res_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;

   // Terminal counts: each counter starts at 0 on entry to its state, so the
   // state is left on the edge where the counter equals (length - 1).
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(WR_GAP - 1);
   localparam logic [31:0]       COMP_LAST = 32'(COMPUTE_CYCLES - 1);
   localparam logic [31:0]       TO_LAST   = 32'(RD_TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_RD,
      LOAD_WR,
      LOAD_GAP,
      COMPUTE,
      DRAIN_REQ,
      DRAIN_WAIT,
      STEP_ADV
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] n_lat;
   logic [31:0]       steps_lat;
   logic [31:0]       step_cnt;
   logic [ADDR_W-1:0] idx;
   logic [GAP_W-1:0]  gap_cnt;
   logic [31:0]       comp_cnt;
   logic [31:0]       to_cnt;

   logic [ADDR_W-1:0] idx_inc;
   logic [31:0]       step_inc;

   // idx never exceeds N-1 before incrementing, and N fits in ADDR_W bits,
   // so idx_inc cannot overflow.
   assign idx_inc  = idx + ADDR_ONE;
   assign step_inc = step_cnt + 32'd1;

   // Every output is a register. Strobes default low each cycle and are
   // raised on the edge that enters the state in which they must be seen,
   // so src_en is high during LOAD_RD, md_read_ctrl during DRAIN_REQ, and
   // md_elem_write during the first LOAD_GAP cycle. md_elem_write and
   // md_read_ctrl therefore can never coincide.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state         <= IDLE;
         n_lat         <= '0;
         steps_lat     <= '0;
         step_cnt      <= '0;
         idx           <= '0;
         gap_cnt       <= '0;
         comp_cnt      <= '0;
         to_cnt        <= '0;
         src_en        <= 1'b0;
         src_addr      <= '0;
         md_d_in       <= '0;
         md_elem_write <= 1'b0;
         md_step       <= '0;
         md_read_ctrl  <= 1'b0;
         res_wr_en     <= 1'b0;
         res_addr      <= '0;
         res_data      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         src_en        <= 1'b0;
         md_elem_write <= 1'b0;
         md_read_ctrl  <= 1'b0;
         res_wr_en     <= 1'b0;
         done          <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  n_lat     <= num_particles;
                  steps_lat <= num_steps;
                  error     <= 1'b0;
                  md_step   <= '0;
                  step_cnt  <= '0;
                  idx       <= '0;
                  // An empty run completes immediately without touching
                  // the BRAM or the MD core.
                  if ((num_particles == '0) || (num_steps == '0)) begin
                     done <= 1'b1;
                  end else begin
                     state    <= LOAD_RD;
                     busy     <= 1'b1;
                     src_en   <= 1'b1;
                     src_addr <= '0;
                  end
               end
            end

            LOAD_RD: begin
               state <= LOAD_WR;
            end

            // src_data is valid in this cycle (one cycle after src_en).
            LOAD_WR: begin
               md_d_in       <= src_data;
               md_elem_write <= 1'b1;
               idx           <= idx_inc;
               gap_cnt       <= '0;
               state         <= LOAD_GAP;
            end

            LOAD_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (idx == n_lat) begin
                     comp_cnt <= '0;
                     state    <= COMPUTE;
                  end else begin
                     src_en   <= 1'b1;
                     src_addr <= idx;
                     state    <= LOAD_RD;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GAP_ONE;
               end
            end

            COMPUTE: begin
               if (comp_cnt == COMP_LAST) begin
                  idx          <= '0;
                  md_read_ctrl <= 1'b1;
                  state        <= DRAIN_REQ;
               end else begin
                  comp_cnt <= comp_cnt + 32'd1;
               end
            end

            DRAIN_REQ: begin
               to_cnt <= '0;
               state  <= DRAIN_WAIT;
            end

            // md_elem_read is only looked at here; strobes arriving in any
            // other state are dropped.
            DRAIN_WAIT: begin
               if (md_elem_read) begin
                  res_wr_en <= 1'b1;
                  res_addr  <= idx;
                  res_data  <= md_d_out;
                  idx       <= idx_inc;
                  if (idx_inc == n_lat) begin
                     state <= STEP_ADV;
                  end else begin
                     md_read_ctrl <= 1'b1;
                     state        <= DRAIN_REQ;
                  end
               end else if (to_cnt == TO_LAST) begin
                  error <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 32'd1;
               end
            end

            STEP_ADV: begin
               md_step  <= md_step + 32'd1;
               step_cnt <= step_inc;
               if (step_inc == steps_lat) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx      <= '0;
                  src_en   <= 1'b1;
                  src_addr <= '0;
                  state    <= LOAD_RD;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_host_sequencer.sv
module tb_md_host_sequencer;

   localparam int ADDR_W         = 9;
   localparam int DIN_W          = 210;
   localparam int DOUT_W         = 192;
   localparam int WR_GAP         = 2;
   localparam int COMPUTE_CYCLES = 40;
   localparam int RD_TIMEOUT     = 60;

   logic              ap_clk;
   logic              ap_rst_n;
   logic              start;
   logic [ADDR_W-1:0] num_particles;
   logic [31:0]       num_steps;
   logic              src_en;
   logic [ADDR_W-1:0] src_addr;
   logic [DIN_W-1:0]  src_data;
   logic [DIN_W-1:0]  md_d_in;
   logic              md_elem_write;
   logic [31:0]       md_step;
   logic              md_read_ctrl;
   logic              md_elem_read;
   logic [DOUT_W-1:0] md_d_out;
   logic              res_wr_en;
   logic [ADDR_W-1:0] res_addr;
   logic [DOUT_W-1:0] res_data;
   logic              busy;
   logic              done;
   logic              error;

   md_host_sequencer #(
      .ADDR_W(ADDR_W), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .WR_GAP(WR_GAP),
      .COMPUTE_CYCLES(COMPUTE_CYCLES), .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
      .num_particles(num_particles), .num_steps(num_steps),
      .src_en(src_en), .src_addr(src_addr), .src_data(src_data),
      .md_d_in(md_d_in), .md_elem_write(md_elem_write), .md_step(md_step),
      .md_read_ctrl(md_read_ctrl), .md_elem_read(md_elem_read),
      .md_d_out(md_d_out), .res_wr_en(res_wr_en), .res_addr(res_addr),
      .res_data(res_data), .busy(busy), .done(done), .error(error)
   );

   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Environment configuration
   bit cfg_simple;       // BRAM[i] = i + 0x10 instead of hashed content
   int cfg_delay;        // MD answer delay after read_ctrl, 0 = random 1..8
   int cfg_ignore_rd;    // 1-based read_ctrl number never answered, 0 = none
   bit cfg_spurious;     // inject a stray md_elem_read during COMPUTE

   // Observations
   logic [DIN_W-1:0]  wr_data_q[$];
   logic [31:0]       wr_step_q[$];
   int                wr_cyc_q[$];
   int                rc_cyc_q[$];
   logic [ADDR_W-1:0] res_addr_q[$];
   logic [DOUT_W-1:0] res_data_q[$];
   int cyc, done_cnt, overlap_cnt, err_rise_cyc, last_wr_cyc;
   int pend, rc_count, resp_idx;
   bit prev_en, prev_err;
   logic [ADDR_W-1:0] prev_addr;
   logic [31:0]       prev_step;

   // Source BRAM content for a given timestep and particle index.
   function automatic logic [DIN_W-1:0] bram_val(input int step, input int a);
      logic [DIN_W-1:0] v;
      v = '0;
      if (cfg_simple) begin
         v[31:0] = a + 32'h10;
      end else begin
         v[31:0]    = (a * 32'h9E3779B1) ^ step;
         v[63:32]   = step * 32'h85EBCA6B + a;
         v[127:96]  = 32'hCAFEF00D ^ a;
         v[209:194] = 16'hB0A7;
      end
      return v;
   endfunction

   // k-th result returned by the MD core model.
   function automatic logic [DOUT_W-1:0] resp_val(input int k);
      logic [DOUT_W-1:0] v;
      v = '0;
      v[31:0]    = k * 32'h01000193 + 32'h811C9DC5;
      v[95:64]   = ~k;
      v[191:176] = 16'h5EED;
      return v;
   endfunction

   // Monitor plus BRAM and MD-core models, all evaluated on the falling edge.
   initial begin
      md_elem_read = 1'b0;
      md_d_out     = '0;
      src_data     = '0;
      cyc = 0; done_cnt = 0; overlap_cnt = 0; err_rise_cyc = 0; last_wr_cyc = 0;
      pend = 0; rc_count = 0; resp_idx = 0;
      prev_en = 1'b0; prev_err = 1'b0; prev_addr = '0; prev_step = '0;
      forever begin
         @(negedge ap_clk);
         cyc++;
         if (md_elem_write) begin
            wr_data_q.push_back(md_d_in);
            wr_step_q.push_back(md_step);
            wr_cyc_q.push_back(cyc);
            last_wr_cyc = cyc;
         end
         if (md_read_ctrl) rc_cyc_q.push_back(cyc);
         if (res_wr_en) begin
            res_addr_q.push_back(res_addr);
            res_data_q.push_back(res_data);
         end
         if (done) done_cnt++;
         if (md_elem_write && md_read_ctrl) overlap_cnt++;
         if (error && !prev_err) err_rise_cyc = cyc;
         prev_err = error;

         // BRAM: data only valid during the cycle after src_en, garbage otherwise
         if (prev_en) src_data = bram_val(int'(prev_step), int'(prev_addr));
         else src_data = DIN_W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         prev_en   = src_en;
         prev_addr = src_addr;
         prev_step = md_step;

         // MD core: answer each read_ctrl after a delay, garbage data otherwise
         md_elem_read = 1'b0;
         md_d_out = DOUT_W'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         if (md_read_ctrl) begin
            rc_count++;
            if (rc_count != cfg_ignore_rd)
               pend = (cfg_delay == 0) ? int'($urandom_range(1, 8)) : cfg_delay;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               md_elem_read = 1'b1;
               md_d_out     = resp_val(resp_idx);
               resp_idx++;
            end
         end
         if (cfg_spurious && pend == 0 && !md_elem_read && last_wr_cyc > 0 &&
             cyc - last_wr_cyc == 10) begin
            md_elem_read = 1'b1;
            md_d_out     = '1;
         end
      end
   end

   task automatic clear_obs();
      @(posedge ap_clk);
      #1;
      wr_data_q.delete(); wr_step_q.delete(); wr_cyc_q.delete(); rc_cyc_q.delete();
      res_addr_q.delete(); res_data_q.delete();
      done_cnt = 0; overlap_cnt = 0; err_rise_cyc = 0; last_wr_cyc = 0;
      pend = 0; rc_count = 0; resp_idx = 0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int b;
      b = 0;
      while (busy && b < budget) begin
         @(negedge ap_clk);
         b++;
      end
      chk({tag, "_finished"}, busy, 1'b0);
      repeat (3) @(negedge ap_clk);
   endtask

   task automatic run_normal(input string tag, input int n, input int s, input int delay,
                             input bit spur, input bit hold);
      int bad_d, bad_s, bad_sp, bad_ra, bad_rd, gap, lim;
      clear_obs();
      cfg_delay = delay; cfg_spurious = spur; cfg_ignore_rd = 0;
      @(negedge ap_clk);
      start = 1'b1; num_particles = ADDR_W'(n); num_steps = 32'(s);
      if (hold) begin
         repeat (60) begin
            @(negedge ap_clk);
            num_particles = ADDR_W'(n + 7);
            num_steps     = 32'(s + 2);
         end
      end else begin
         @(negedge ap_clk);
      end
      start = 1'b0;
      wait_idle(tag, n * s * 20 + s * (COMPUTE_CYCLES + 20) + 200);

      chk({tag, "_wr_count"}, wr_data_q.size(), n * s);
      chk({tag, "_rc_count"}, rc_cyc_q.size(), n * s);
      chk({tag, "_res_count"}, res_data_q.size(), n * s);
      bad_d = 0; bad_s = 0; bad_sp = 0; bad_ra = 0; bad_rd = 0;
      lim = (wr_data_q.size() < n * s) ? wr_data_q.size() : n * s;
      for (int k = 0; k < lim; k++) begin
         if (wr_data_q[k] !== bram_val(k / n, k % n)) bad_d++;
         if (wr_step_q[k] !== 32'(k / n)) bad_s++;
         if ((k % n) != 0 && (wr_cyc_q[k] - wr_cyc_q[k-1]) != 2 + WR_GAP) bad_sp++;
      end
      lim = (res_data_q.size() < n * s) ? res_data_q.size() : n * s;
      for (int k = 0; k < lim; k++) begin
         if (res_addr_q[k] !== ADDR_W'(k % n)) bad_ra++;
         if (res_data_q[k] !== resp_val(k)) bad_rd++;
      end
      chk({tag, "_wr_data_bad"}, bad_d, 0);
      chk({tag, "_wr_step_bad"}, bad_s, 0);
      chk({tag, "_wr_spacing_bad"}, bad_sp, 0);
      chk({tag, "_res_addr_bad"}, bad_ra, 0);
      chk({tag, "_res_data_bad"}, bad_rd, 0);
      if (wr_cyc_q.size() >= n && rc_cyc_q.size() >= 1) begin
         gap = rc_cyc_q[0] - wr_cyc_q[n-1];
         chk({tag, "_compute_gap_in_range"},
             (gap >= COMPUTE_CYCLES && gap <= COMPUTE_CYCLES + WR_GAP + 2), 1'b1);
      end else begin
         chk({tag, "_compute_gap_seen"}, 1'b0, 1'b1);
      end
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_md_step_final"}, md_step, 32'(s));
      chk({tag, "_strobe_overlap"}, overlap_cnt, 0);
   endtask

   initial begin
      int b, n, s;
      ap_rst_n = 1'b0; start = 1'b0; num_particles = '0; num_steps = '0;
      cfg_simple = 1'b0; cfg_delay = 5; cfg_ignore_rd = 0; cfg_spurious = 1'b0;

      // Reset state
      repeat (3) @(negedge ap_clk);
      chk("rst_strobes", {src_en, md_elem_write, md_read_ctrl, res_wr_en, busy, done, error}, 7'd0);
      chk("rst_md_d_in", md_d_in, '0);
      chk("rst_md_step", md_step, '0);
      chk("rst_addrs", {src_addr, res_addr}, '0);
      chk("rst_res_data", res_data, '0);
      ap_rst_n = 1'b1;
      repeat (2) @(negedge ap_clk);

      // Basic run: N=4, one step, BRAM[i] = i + 0x10
      cfg_simple = 1'b1;
      run_normal("basic", 4, 1, 5, 1'b0, 1'b0);
      if (wr_data_q.size() == 4) begin
         chk("basic_first_rec", wr_data_q[0], 'h10);
         chk("basic_last_rec", wr_data_q[3], 'h13);
      end else begin
         chk("basic_rec_present", wr_data_q.size(), 4);
      end
      cfg_simple = 1'b0;

      // Long run: N=300, three steps
      run_normal("long", 300, 3, 5, 1'b0, 1'b0);

      // Randomized runs with random MD answer latency
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(1, 12));
         s = int'($urandom_range(1, 3));
         run_normal($sformatf("rand%0d", r), n, s, 0, 1'b0, 1'b0);
      end

      // start held high while busy must not restart or change counts
      run_normal("hold", 10, 2, 3, 1'b0, 1'b1);

      // Empty runs complete the next cycle with no strobes
      clear_obs();
      @(negedge ap_clk);
      start = 1'b1; num_particles = '0; num_steps = 32'd5;
      @(negedge ap_clk);
      chk("zero_n_done", done, 1'b1);
      chk("zero_n_busy", busy, 1'b0);
      start = 1'b0;
      @(negedge ap_clk);
      chk("zero_n_done_pulse", done, 1'b0);
      start = 1'b1; num_particles = ADDR_W'(5); num_steps = 32'd0;
      @(negedge ap_clk);
      chk("zero_s_done", done, 1'b1);
      start = 1'b0;
      repeat (10) @(negedge ap_clk);
      chk("zero_no_strobes", wr_data_q.size() + rc_cyc_q.size() + res_data_q.size(), 0);

      // MD core never answers the second read_ctrl
      clear_obs();
      cfg_delay = 3; cfg_ignore_rd = 2;
      @(negedge ap_clk);
      start = 1'b1; num_particles = ADDR_W'(4); num_steps = 32'd1;
      @(negedge ap_clk);
      start = 1'b0;
      wait_idle("tmo", 4 * 20 + COMPUTE_CYCLES + RD_TIMEOUT + 200);
      chk("tmo_error", error, 1'b1);
      chk("tmo_done_count", done_cnt, 0);
      chk("tmo_rc_count", rc_cyc_q.size(), 2);
      chk("tmo_res_count", res_data_q.size(), 1);
      if (rc_cyc_q.size() >= 2)
         chk("tmo_latency_in_range", (err_rise_cyc - rc_cyc_q[1] >= RD_TIMEOUT &&
                                       err_rise_cyc - rc_cyc_q[1] <= RD_TIMEOUT + 3), 1'b1);
      clear_obs();
      cfg_ignore_rd = 0;
      @(negedge ap_clk);
      start = 1'b1; num_particles = ADDR_W'(2); num_steps = 32'd1;
      @(negedge ap_clk);
      start = 1'b0;
      chk("tmo_error_cleared", error, 1'b0);
      wait_idle("tmo_next", 2 * 20 + COMPUTE_CYCLES + 200);
      chk("tmo_next_done", done_cnt, 1);
      chk("tmo_next_res_count", res_data_q.size(), 2);

      // Reset asserted mid-load at idx=150
      clear_obs();
      cfg_delay = 5;
      @(negedge ap_clk);
      start = 1'b1; num_particles = ADDR_W'(300); num_steps = 32'd1;
      @(negedge ap_clk);
      start = 1'b0;
      b = 0;
      while (wr_data_q.size() < 150 && b < 2000) begin
         @(negedge ap_clk);
         b++;
      end
      chk("midrst_reached_150", wr_data_q.size(), 150);
      @(posedge ap_clk);
      #3 ap_rst_n = 1'b0;
      #1;
      chk("midrst_async_strobes", {src_en, md_elem_write, md_read_ctrl, res_wr_en, busy, done, error}, 7'd0);
      chk("midrst_async_data", {md_d_in, src_addr, res_addr}, '0);
      chk("midrst_async_step_res", {md_step, res_data}, '0);
      repeat (3) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (20) @(negedge ap_clk);
      chk("midrst_idle", busy, 1'b0);
      chk("midrst_no_done", done_cnt, 0);
      chk("midrst_no_more_writes", wr_data_q.size(), 150);
      run_normal("after_rst", 2, 1, 2, 1'b0, 1'b0);

      // Stray md_elem_read during COMPUTE must not reach the result buffer
      run_normal("spur", 3, 2, 4, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
